// File: rtl/pbkdf2_final_ctrl.sv
// pbkdf2_final_ctrl: assembles the 132-byte PBKDF2 message B || INT(1), launches the HMAC core and hands its digest downstream.
//   clk/rst                  clock, asynchronous active-high reset
//   in_valid/in_ready        upstream key + block handshake (ready only in IDLE)
//   in_key, in_block         256-bit HMAC key, 1024-bit ROMix block (byte i at [8*i +: 8])
//   hmac_enable              one-cycle start pulse to the core
//   hmac_key, hmac_msg       registered key and 1056-bit message, stable until the next accept
//   hmac_hash, hmac_done     digest and its single-cycle valid pulse from the core
//   out_valid/out_ready      downstream digest handshake, out_hash holds the captured digest
//   busy                     state is not IDLE
//   timeout_err              sticky watchdog abort flag
// Optional watchdog: define PBKDF2_FINAL_WATCHDOG_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module pbkdf2_final_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [255:0]  in_key,
  input  logic [1023:0] in_block,
  output logic          hmac_enable,
  output logic [255:0]  hmac_key,
  output logic [1055:0] hmac_msg,
  input  logic [255:0]  hmac_hash,
  input  logic          hmac_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [255:0]  out_hash,
  output logic          busy,
  output logic          timeout_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;
  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_accept;
  logic       w_capture;
  logic       w_expire;
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_capture   = hmac_done && (r_state == S_WAIT);
  assign in_ready    = (r_state == S_IDLE);
  assign hmac_enable = (r_state == S_START);
  assign out_valid   = (r_state == S_OUT);
  assign busy        = (r_state != S_IDLE);
  always_comb begin
    w_next = r_state == S_IDLE  ? (in_valid ? S_START : S_IDLE) :
             r_state == S_START ? S_WAIT :
             r_state == S_WAIT  ? (hmac_done ? S_OUT : w_expire ? S_IDLE : S_WAIT) :
                                  (out_ready ? S_IDLE : S_OUT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      hmac_key <= '0;
      hmac_msg <= '0;
      out_hash <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        hmac_key <= in_key;
        // byte 131 (top of the vector) carries the low byte of big-endian INT(1)
        hmac_msg <= {8'h01, 24'h0, in_block};
      end
      if (w_capture) out_hash <= hmac_hash;
    end
  end
`ifdef PBKDF2_FINAL_WATCHDOG_EN
  localparam int CW = (TIMEOUT_CYCLES > 1023) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  // the counter equals the number of completed WAIT cycles, so expiring on TIMEOUT_CYCLES-1
  // bounds WAIT to exactly TIMEOUT_CYCLES cycles; a done in that last cycle still wins
  assign w_expire    = (r_state == S_WAIT) && !hmac_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      r_err <= w_accept ? 1'b0 : w_expire ? 1'b1 : r_err;
    end
  end
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/pbkdf2_final_ctrl.md
# pbkdf2_final_ctrl

Control and message-assembly stage directly upstream of `hmac_sha256_32_132` in the scrypt datapath. Accepts the 1024-bit ROMix output block B and a 256-bit HMAC key, builds the 132-byte PBKDF2 message B || INT(1), and launches the HMAC core with a one-cycle enable. It then waits for `hash_done`, captures the 256-bit digest, and presents it downstream over a valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1023: maximum cycles spent in WAIT before abort; only used with the watchdog compiled in.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream has a block/key pair.
- `in_ready`  out  1  block can accept a pair (high only in IDLE).
- `in_key`  in  256  HMAC key.
- `in_block`  in  1024  ROMix output B; byte i at `[8*i +: 8]`.
- `hmac_enable`  out  1  one-cycle start pulse to the HMAC core.
- `hmac_key`  out  256  registered key to the core.
- `hmac_msg`  out  1056  registered 132-byte message to the core.
- `hmac_hash`  in  256  digest from the core.
- `hmac_done`  in  1  digest valid, single-cycle pulse.
- `out_valid`  out  1  `out_hash` valid.
- `out_ready`  in  1  downstream accepts the hash.
- `out_hash`  out  256  captured digest.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  sticky watchdog abort flag.

## Operation
- FSM states: IDLE, START, WAIT, OUT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `hmac_key` <= `in_key`;
  - latch `hmac_msg[1023:0]` <= `in_block`;
  - latch `hmac_msg[1055:1024]` <= bytes 128..131 = 8'h00, 8'h00, 8'h00, 8'h01 (INT(1), big-endian), i.e. `hmac_msg[1055:1048]`=8'h01 and the rest of the field zero;
  - clear `timeout_err`;
  - go to START.
- START: `hmac_enable`=1 for exactly this cycle; go to WAIT.
- WAIT: on `hmac_done`, `out_hash` <= `hmac_hash` and go to OUT.
- OUT: `out_valid`=1. On `out_ready`, go to IDLE. `out_hash` holds its value until the next capture.
- `hmac_key` and `hmac_msg` change only on accept, so they are stable throughout START, WAIT and OUT.
- `hmac_done` is ignored in IDLE, START and OUT (no capture, no state change).
- `in_valid` is ignored outside IDLE. Upstream must hold its data until `in_ready`.
- `busy` = (state != IDLE).

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `in_ready`=1; `hmac_enable`=0, `out_valid`=0, `busy`=0, `timeout_err`=0; `hmac_key`, `hmac_msg` and `out_hash` are all-zero.
- Accept in cycle N -> `hmac_enable` high in cycle N+1 only -> WAIT from N+2.
- `hmac_done` sampled in cycle M -> `out_valid` high from M+1.
- `out_valid && out_ready` in cycle K -> IDLE and `in_ready`=1 in K+1. No back-to-back accept in the same cycle as the handshake.
- Minimum accept-to-accept spacing is 4 cycles plus HMAC latency.
- Reset mid-operation: immediate return to the reset state. A digest in flight in the core is discarded; a later `hmac_done` arriving in IDLE is ignored.
- `hmac_done` in the same cycle as the START pulse is ignored (START does not sample it).

## Configuration
- `PBKDF2_FINAL_WATCHDOG_EN` defined:
  - 10-bit-minimum cycle counter, cleared on entry to WAIT, increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `hmac_done`: go to IDLE, set `timeout_err` (sticky until next accept or reset), never assert `out_valid` for that job.
- Not defined: no counter. WAIT lasts indefinitely. `timeout_err` is tied to 0.

## Test plan
- Reset then all-0x01 key, all-0x01 B, `in_valid` for 1 cycle -> `hmac_msg[1023:0]` all 0x01; `hmac_msg[1055:1048]`=8'h01; `hmac_msg[1047:1024]`=0; `hmac_enable` exactly one pulse, in the cycle after accept.
- Model core returns `hmac_done` with `hmac_hash`=256'hA5…A5 after 70 cycles, `out_ready` held low 5 cycles -> `out_valid` high from done+1, held stable with `out_hash`=A5…A5 until `out_ready`, then IDLE next cycle.
- Spurious `hmac_done` in IDLE and in OUT with a different hash -> no state change, `out_hash` unchanged.
- `in_valid` asserted while in WAIT with a new B -> not accepted, `hmac_msg` unchanged, `in_ready`=0.
- Assert `rst` mid-WAIT, then deliver `hmac_done` -> all outputs at reset values, digest ignored, `busy`=0.
- With `PBKDF2_FINAL_WATCHDOG_EN`, `TIMEOUT_CYCLES`=20, no `hmac_done` -> `timeout_err`=1 after 20 WAIT cycles, back in IDLE, `out_valid` never high; the next accept clears `timeout_err`.
